// File: rtl/ps2_host_cmd_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8N1-odd frame, ack check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_cmd_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);
  localparam int CW = $clog2(INHIBIT_CYCLES + 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_host_cmd_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_clk_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [8:0]    r_frame;
  logic          r_sh_oe, r_ack_err;
  logic          w_clk_s, w_dat_s, w_fall, w_accept, w_inh_last, w_abort, w_bit;

  // Pins idle high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_clk_s    = r_clk_sync[1];
  assign w_dat_s    = r_dat_sync[1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = ~cmd_ready;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_inh_last = (r_cnt == CW'(INHIBIT_CYCLES - 1));
  assign w_bit      = (r_idx < 4'd9) ? r_frame[r_idx] : 1'b1;
  assign ack_err    = done & r_ack_err;
  assign timeout    = w_abort;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;

  // Device clock activity is the only thing that keeps the watchdog from expiring.
  always_ff @(posedge clk) begin
    if (reset || w_accept)
      r_wdog <= '0;
    else if ((r_state == S_SHIFT || r_state == S_ACK) && w_fall)
      r_wdog <= '0;
    else if (r_state != S_IDLE)
      r_wdog <= r_wdog + 1'b1;
  end

  assign w_abort = (r_state != S_IDLE) && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_INHIBIT;
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (w_inh_last) begin
          ps2_dat_oe = 1'b1;
          w_next     = S_REQ;
        end
      end
      S_REQ: begin
        ps2_dat_oe = 1'b1;
        w_next     = S_SHIFT;
      end
      S_SHIFT: begin
        ps2_dat_oe = r_sh_oe;
        if (w_fall && r_idx == 4'd9) w_next = S_ACK;
      end
      S_ACK:       if (w_fall) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (w_clk_s && w_dat_s) begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next     = S_IDLE;
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 4'd0;
      r_frame   <= 9'd0;
      r_sh_oe   <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_frame <= {~^cmd_data, cmd_data};
        r_cnt   <= '0;
      end else if (r_state == S_INHIBIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Start bit stays driven until the first device falling edge; the stop slot releases the line.
      if (r_state == S_REQ) begin
        r_idx   <= 4'd0;
        r_sh_oe <= 1'b1;
      end else if (r_state == S_SHIFT && w_fall) begin
        r_idx   <= r_idx + 1'b1;
        r_sh_oe <= ~w_bit;
      end
      if (r_state == S_ACK && w_fall) r_ack_err <= w_dat_s;
    end
  end
endmodule

// File: doc/ps2_host_cmd_tx.md
Name: ps2_host_cmd_tx

Overview:
- PS/2 host-to-device command transmitter: the send side of the PS/2 port, complementing the existing device-to-host scan-code receive path.
- Accepts one byte from the Nios II-side command register over a valid/ready handshake.
- Runs the host request-to-send sequence on PS2_CLK/PS2_DAT, shifts out data, odd parity and stop, then checks the device ack bit.
- Open-drain style: outputs are drive-low enables. The top level ties each pin as "oe ? 1'b0 : 1'bZ" and feeds the pin back on the *_in ports.

Parameters:
- INHIBIT_CYCLES, 5000, clocks PS2_CLK is held low before request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, watchdog limit per transfer (15 ms at 50 MHz); used only with PS2_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin value (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, can accept a command.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- ack_err  out  1  valid with done: 1 = device did not ack (data high at ack clock).
- timeout  out  1  one-cycle pulse on watchdog expiry (constant 0 without PS2_TX_TIMEOUT_EN).

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, acting on the next rising clk edge.
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, cmd_ready=1, busy=0, done=0, ack_err=0, timeout=0; state IDLE.
- A reset mid-transfer releases both lines on the reset clock edge; no partial-frame recovery.
- Input conditioning: ps2_clk_in and ps2_dat_in pass through 2-FF synchronizers. The falling edge of PS2_CLK is sync_prev=1 and sync=0.
- Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. cmd_data is latched and the parity bit is computed as ~^cmd_data (odd parity). cmd_ready=0 and busy=1 from the next cycle until done or timeout.
- States:
  - IDLE: lines released. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES clocks. On the last cycle, set ps2_dat_oe=1 (start bit 0) and go to REQ.
  - REQ: ps2_clk_oe=0, ps2_dat_oe=1, bit index=0. Go to SHIFT.
  - SHIFT: on each device falling edge, present the next frame bit by setting ps2_dat_oe = ~bit. Order: falling edges 1-8 carry data[0]..data[7], edge 9 carries parity, edge 10 releases data (stop=1). After edge 10, go to ACK.
  - ACK: on the next falling edge, sample synced data. ack_err = sampled value (0 = ack ok). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk=1 and data=1 on the same cycle, then pulse done for one cycle and return to IDLE. cmd_ready=1 on the cycle after done.
- Counters: the inhibit counter width is $clog2(INHIBIT_CYCLES+1). The bit index is 4 bits and never wraps within a frame.
- cmd_valid while busy is ignored and not queued. cmd_data changes after accept have no effect.
- If the device pulls data low early during SHIFT, the block ignores it; the bits already driven continue.

Optional Feature:
- PS2_TX_TIMEOUT_EN defined: a watchdog counts from accept. It clears whenever a falling edge is seen in SHIFT or ACK.
- If the watchdog reaches TIMEOUT_CYCLES in any non-IDLE state:
  - both oe are released the same cycle;
  - timeout pulses for 1 cycle;
  - done is not asserted;
  - state returns to IDLE, with cmd_ready=1 the next cycle.
- PS2_TX_TIMEOUT_EN undefined: no watchdog logic; timeout is tied 0, and a missing device clock hangs in the waiting state until reset.

Test Plan:
- Inhibit timing: with INHIBIT_CYCLES=5000, accept 0xFF -> ps2_clk_oe high exactly 5000 cycles. ps2_dat_oe rises on the last inhibit cycle; clk is then released.
- Frame bits: the device model clocks at 12.5 kHz and samples on rising edges.
  - 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - 0xED -> bits 1,0,1,1,0,1,1,1, parity 1.
  - Device drives ack 0 -> done=1, ack_err=0.
- No ack: the device leaves data high on clock 11 -> done pulse with ack_err=1, lines released, cmd_ready=1 the next cycle.
- Busy rejection: cmd_valid=1 with 0xAA held throughout the 0xFF transfer -> exactly one frame sent (0xFF). 0xAA is accepted only after cmd_ready returns.
- Reset mid-frame: assert reset after the 4th falling edge -> both oe 0 on that edge, outputs at reset values. The next command 0xF4 sends a correct full frame.
- Timeout (PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=750000): the device never clocks -> timeout pulses 750000 cycles after accept, oe both 0, no done. Without the macro, timeout stays 0 and busy stays 1.
